// File: rtl/int_ctrl_if.sv
// Fetch-stage interrupt handshake: controller raises ipu_int, fetch acks, pipeline signals done.
// Master is the controller side; slave is the fetch/pipeline side.
interface int_ctrl_if #(
  parameter int SRC_W = 2
);
  logic             ipu_int;
  logic             int_ack;
  logic             int_done;
  logic [SRC_W-1:0] int_src;
  logic             int_active;

  modport master (
    output ipu_int,
    output int_src,
    output int_active,
    input  int_ack,
    input  int_done
  );

  modport slave (
    input  ipu_int,
    input  int_src,
    input  int_active,
    output int_ack,
    output int_done
  );
endinterface

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-latched pending bits, fixed lowest-index priority, one service at a time.
// ipu_int is raised the cycle after a candidate is seen in IDLE; new services wait for int_done plus a RETIRE cycle.
module int_ctrl #(
  parameter int NUM_SRC     = 4,
  parameter int SRC_W       = 2,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq,
  input  logic               cfg_we,
  input  logic [NUM_SRC-1:0] cfg_mask,
  input  logic               err_clr,
  int_ctrl_if.master         hs,
  output logic [NUM_SRC-1:0] pending,
  output logic               err_ack,
  output logic               err_done
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RAISE   = 3'd1;
  localparam logic [2:0] ACK     = 3'd2;
  localparam logic [2:0] SERVICE = 3'd3;
  localparam logic [2:0] RETIRE  = 3'd4;

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  logic [2:0]         state;
  logic [2:0]         state_nxt;
  logic [NUM_SRC-1:0] irq_q;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] pend_q;
  logic [NUM_SRC-1:0] pend_nxt;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] cand;
  logic [NUM_SRC-1:0] clr_vec;
  logic [NUM_SRC-1:0] set_vec;
  logic [SRC_W-1:0]   src_q;
  logic [SRC_W-1:0]   winner;
  logic [CNT_W-1:0]   cnt;
  logic               any_cand;
  logic               take;
  logic               ack_tmo;
  logic               spurious;

  assign rise     = irq & ~irq_q;
  assign cand     = pend_q & ~mask;
  assign any_cand = |cand;

  // Scan high to low so the lowest set index is the final assignment.
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) winner = SRC_W'(i);
    end
  end

  assign take    = (state == IDLE) && any_cand && !hs.int_done;
  assign ack_tmo = (state == ACK) && !hs.int_ack && (cnt == CNT_W'(ACK_TIMEOUT - 1));

  assign spurious = (hs.int_done && ((state == IDLE) || (state == RAISE) || (state == ACK)))
                 || (hs.int_ack && (state != ACK));

  assign clr_vec  = take    ? (NUM_SRC'(1) << winner) : '0;
  assign set_vec  = ack_tmo ? (NUM_SRC'(1) << src_q)  : '0;
  // A rise in the same cycle as the clear re-arms the bit.
  assign pend_nxt = (pend_q & ~clr_vec) | rise | set_vec;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = RAISE;
      RAISE:   state_nxt = ACK;
      ACK: begin
        if (hs.int_ack)   state_nxt = SERVICE;
        else if (ack_tmo) state_nxt = IDLE;
      end
      SERVICE: if (hs.int_done) state_nxt = RETIRE;
      RETIRE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      irq_q    <= '0;
      mask     <= '1;
      pend_q   <= '0;
      src_q    <= '0;
      cnt      <= '0;
      err_ack  <= 1'b0;
      err_done <= 1'b0;
    end else begin
      state  <= state_nxt;
      irq_q  <= irq;
      pend_q <= pend_nxt;
      if (cfg_we) mask  <= cfg_mask;
      if (take)   src_q <= winner;
      if (state == ACK) cnt <= cnt + CNT_W'(1);
      else              cnt <= '0;
      if (ack_tmo)      err_ack <= 1'b1;
      else if (err_clr) err_ack <= 1'b0;
      if (spurious)     err_done <= 1'b1;
      else if (err_clr) err_done <= 1'b0;
    end
  end

  assign hs.ipu_int    = (state == RAISE);
  assign hs.int_active = (state == RAISE) || (state == ACK) || (state == SERVICE);
  assign hs.int_src    = src_q;
  assign pending       = pend_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios then random traffic, compared every cycle against a
// transaction-level model of the interrupt lifecycle with a fetch/pipeline responder.
module tb_int_ctrl;
  localparam int NUM_SRC     = 4;
  localparam int SRC_W       = 2;
  localparam int ACK_TIMEOUT = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_SRC-1:0] irq;
  logic               cfg_we;
  logic [NUM_SRC-1:0] cfg_mask;
  logic               err_clr;
  logic [NUM_SRC-1:0] pending;
  logic               err_ack;
  logic               err_done;

  int_ctrl_if #(.SRC_W(SRC_W)) hs ();

  int_ctrl #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .irq      (irq),
    .cfg_we   (cfg_we),
    .cfg_mask (cfg_mask),
    .err_clr  (err_clr),
    .hs       (hs),
    .pending  (pending),
    .err_ack  (err_ack),
    .err_done (err_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int last_raise = -100;

  // Responder knobs: fetch acks one cycle after ipu_int when ack_en; pipeline finishes after done_delay.
  bit ack_en = 1'b1;
  int done_delay = 2;

  // Model: where the current interrupt is in its lifecycle, plus register images.
  logic [NUM_SRC-1:0] m_pend, m_mask, m_prev;
  int  m_src;
  bit  m_eack, m_edone;
  bit  m_raise, m_wait, m_svc, m_ret;
  int  m_ack_cnt, m_svc_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_mask = '1; m_prev = '0; m_src = 0;
    m_eack = 0; m_edone = 0;
    m_raise = 0; m_wait = 0; m_svc = 0; m_ret = 0;
    m_ack_cnt = 0; m_svc_cnt = 0;
  endtask

  function automatic int first_set(input logic [NUM_SRC-1:0] v);
    for (int i = 0; i < NUM_SRC; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic check_outputs();
    chk("ipu_int", hs.ipu_int, m_raise);
    chk("int_active", hs.int_active, m_raise | m_wait | m_svc);
    chk("int_src", hs.int_src, m_src);
    chk("pending", pending, m_pend);
    chk("err_ack", err_ack, m_eack);
    chk("err_done", err_done, m_edone);
    if (hs.ipu_int) begin
      chk("raise_gap_ge4", (cyc - last_raise) >= 4, 1);
      last_raise = cyc;
    end
  endtask

  // Apply one cycle of inputs, predict the next state, then sample after the edge.
  task automatic step(input logic [NUM_SRC-1:0] i_irq, input bit we, input logic [NUM_SRC-1:0] nm,
                      input bit clr, input bit sp_ack, input bit sp_done);
    bit ack, done, evt;
    logic [NUM_SRC-1:0] rise, cand;
    int w;
    ack  = (ack_en && m_wait && m_ack_cnt == 0) || sp_ack;
    done = (m_svc && m_svc_cnt >= done_delay) || sp_done;
    irq = i_irq; cfg_we = we; cfg_mask = nm; err_clr = clr;
    hs.int_ack = ack; hs.int_done = done;

    rise = i_irq & ~m_prev;
    evt  = (done && !(m_svc || m_ret)) || (ack && !m_wait);
    if (clr) begin m_edone = 0; m_eack = 0; end
    if (evt) m_edone = 1;
    if (m_raise) begin
      m_raise = 0; m_wait = 1; m_ack_cnt = 0;
    end else if (m_wait) begin
      if (ack) begin
        m_wait = 0; m_svc = 1; m_svc_cnt = 0;
      end else begin
        m_ack_cnt++;
        if (m_ack_cnt == ACK_TIMEOUT) begin
          m_wait = 0; m_eack = 1; m_pend[m_src] = 1'b1;
        end
      end
    end else if (m_svc) begin
      if (done) begin m_svc = 0; m_ret = 1; end
      else m_svc_cnt++;
    end else if (m_ret) begin
      m_ret = 0;
    end else begin
      cand = m_pend & ~m_mask;
      w = first_set(cand);
      if (w >= 0 && !done) begin
        m_src = w; m_pend[w] = 1'b0; m_raise = 1;
      end
    end
    m_pend = m_pend | rise;
    if (we) m_mask = nm;
    m_prev = i_irq;

    @(posedge clk); #1;
    cyc++;
    check_outputs();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step('0, 0, '0, 0, 0, 0);
  endtask

  task automatic pulse(input logic [NUM_SRC-1:0] v);
    step(v, 0, '0, 0, 0, 0);
    step('0, 0, '0, 0, 0, 0);
  endtask

  task automatic run_until_svc(input int budget);
    int b;
    b = budget;
    while (!m_svc && b > 0) begin
      step('0, 0, '0, 0, 0, 0);
      b--;
    end
    chk("service_reached", m_svc, 1);
  endtask

  initial begin
    logic [NUM_SRC-1:0] cur;
    int b;
    rst = 1'b0; irq = '0; cfg_we = 0; cfg_mask = '0; err_clr = 0;
    hs.int_ack = 0; hs.int_done = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ipu_int", hs.ipu_int, 0);
    chk("rst_int_active", hs.int_active, 0);
    chk("rst_pending", pending, 0);
    chk("rst_err_ack", err_ack, 0);
    rst = 1'b1;

    // Serve source 0, then pull reset while it is in service.
    done_delay = 20;
    step('0, 1, '0, 0, 0, 0);
    pulse(4'b0001);
    run_until_svc(20);
    idle_steps(2);
    irq = '0; cfg_we = 0; err_clr = 0; hs.int_ack = 0; hs.int_done = 0;
    #3 rst = 1'b0;
    #1;
    chk("arst_ipu_int", hs.ipu_int, 0);
    chk("arst_int_active", hs.int_active, 0);
    chk("arst_int_src", hs.int_src, 0);
    chk("arst_pending", pending, 0);
    chk("arst_err_done", err_done, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;

    // Enable after reset and request source 2.
    done_delay = 2;
    step('0, 1, '0, 0, 0, 0);
    pulse(4'b0100);
    idle_steps(8);

    // Two simultaneous requests: source 1 wins, source 3 follows.
    done_delay = 10;
    pulse(4'b1010);
    idle_steps(40);

    // Masked source latches pending but is not raised until unmasked.
    done_delay = 2;
    step('0, 1, 4'b0001, 0, 0, 0);
    pulse(4'b0001);
    idle_steps(4);
    step('0, 1, '0, 0, 0, 0);
    idle_steps(10);

    // Fetch never acks: timeout, pending restored, re-raised, then cleared.
    ack_en = 0;
    pulse(4'b0010);
    b = 20;
    while (!m_eack && b > 0) begin step('0, 0, '0, 0, 0, 0); b--; end
    chk("timeout_reached", m_eack, 1);
    ack_en = 1;
    idle_steps(12);
    step('0, 0, '0, 1, 0, 0);
    idle_steps(2);

    // Spurious int_done while idle.
    step('0, 0, '0, 0, 0, 1);
    idle_steps(3);
    step('0, 0, '0, 1, 0, 0);

    // Same source requests again during its own service.
    done_delay = 6;
    pulse(4'b0100);
    run_until_svc(20);
    pulse(4'b0100);
    idle_steps(30);

    // Random traffic.
    cur = '0;
    for (int i = 0; i < 600; i++) begin
      if (m_raise) begin
        done_delay = $urandom_range(0, 4);
        ack_en = ($urandom_range(0, 7) != 0);
      end
      if ($urandom_range(0, 3) == 0) cur = 4'($urandom);
      step(cur,
           $urandom_range(0, 15) == 0,
           ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000,
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 39) == 0);
    end
    ack_en = 1;
    idle_steps(20);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
